// File: rtl/div_radix2_core_pkg.sv
// Shared constants for the radix-2 divider core.
//   XLEN : machine word width, default operand width of the divider.
package div_radix2_core_pkg;
  localparam int XLEN = 32;
endpackage

// File: rtl/div_radix2_core_clz.sv
// div_clz: parameterized combinational leading-zero counter.
//   data_i  [DATA_WIDTH-1:0]        : value to scan
//   count_o [clog2(DATA_WIDTH):0]   : number of leading zeros, DATA_WIDTH for 0
module div_clz #(
  parameter int DATA_WIDTH = 32,
  parameter int CW         = $clog2(DATA_WIDTH) + 1
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CW-1:0]         count_o
);
  // Scan LSB to MSB so the highest set bit wins.
  always_comb begin
    count_o = CW'(DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (data_i[i]) count_o = CW'(DATA_WIDTH - 1 - i);
    end
  end
endmodule

// File: rtl/div_radix2_core.sv
// div_radix2_core: iterative unsigned restoring divider, one quotient bit per
// cycle, leading-zero dividend bits skipped, one-cycle fast paths.
//   clk, rst_n           : clock, async active-low reset
//   start                : request pulse, accepted only while busy=0
//   dividend, divisor    : unsigned operands, sampled on the accepted start
//   busy                 : RUN in progress
//   done                 : one-cycle result strobe
//   quotient, remainder  : registered results, held until the next result
//   divisor_is_zero      : registered flag for the last accepted operation
module div_radix2_core
  import div_radix2_core_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  divisor_is_zero
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   sh_q, sh_d;       // normalized dividend, MSB feeds R
  logic [W-1:0]   rem_q, rem_d;     // partial remainder (always < divisor)
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   q_out_q, q_out_d;
  logic [W-1:0]   r_out_q, r_out_d;
  logic           dz_q, dz_d;
  logic           done_q, done_d;

  logic [CW-1:0]  clz;
  logic [CW-1:0]  k;
  logic           idle;
  logic [W-1:0]   src_r, src_sh, src_q, src_dvs;
  logic [W:0]     r_sh, diff;
  logic           qbit;
  logic [W-1:0]   step_r, step_sh, step_q;

  div_clz #(.DATA_WIDTH(W), .CW(CW)) u_clz (
    .data_i  (dividend),
    .count_o (clz)
  );

  assign k    = CW'(W) - clz;
  assign idle = (state_q == IDLE);

  // The first iteration is folded into the accept edge so that a K-bit
  // dividend finishes K edges after start; in IDLE the step consumes the
  // freshly normalized operands instead of the registers.
  always_comb begin
    src_r   = idle ? '0 : rem_q;
    src_sh  = idle ? (dividend << clz) : sh_q;
    src_q   = idle ? '0 : quo_q;
    src_dvs = idle ? divisor : dvs_q;
    r_sh    = {src_r, src_sh[W-1]};
    diff    = r_sh - {1'b0, src_dvs};
    qbit    = ~diff[W];
    step_r  = qbit ? diff[W-1:0] : r_sh[W-1:0];
    step_sh = src_sh << 1;
    step_q  = (src_q << 1) | W'(qbit);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            q_out_d = '1;
            r_out_d = dividend;
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end else if (dividend < divisor) begin
            q_out_d = '0;
            r_out_d = dividend;
            dz_d    = 1'b0;
            done_d  = 1'b1;
          end else if (k == CW'(1)) begin
            // Single-bit dividend: the folded iteration is the whole job.
            q_out_d = step_q;
            r_out_d = step_r;
            dz_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = k - CW'(1);
            sh_d    = step_sh;
            rem_d   = step_r;
            quo_d   = step_q;
            dvs_d   = divisor;
          end
        end
      end
      RUN: begin
        sh_d  = step_sh;
        rem_d = step_r;
        quo_d = step_q;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_out_d = step_q;
          r_out_d = step_r;
          dz_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy            = (state_q == RUN);
  assign done            = done_q;
  assign quotient        = q_out_q;
  assign remainder       = r_out_q;
  assign divisor_is_zero = dz_q;
endmodule

// File: tb/tb_div_radix2_core.sv
// Scoreboard bench for div_radix2_core: the driver pushes the expected result
// and latency on every accepted start; a negedge monitor pops and compares on
// every done.
module tb_div_radix2_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, divisor_is_zero;
  logic [31:0] quotient, remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_exp_g = 0;

  div_radix2_core dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .dividend        (dividend),
    .divisor         (divisor),
    .busy            (busy),
    .done            (done),
    .quotient        (quotient),
    .remainder       (remainder),
    .divisor_is_zero (divisor_is_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain division; normal-path latency is the dividend bit length.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.acc = 0;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else if (a < b) begin
      e.q = '0; e.r = a; e.dz = 1'b0; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
      e.lat = $clog2(longint'(a) + 64'd1);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 64'(quotient), 64'(e.q));
        chk("remainder", 64'(remainder), 64'(e.r));
        chk("divisor_is_zero", 64'(divisor_is_zero), 64'(e.dz));
        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  // Drive start in the current cycle (caller is between edges).
  task automatic issue_now(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(a, b);
    e.acc = cyc;
    busy_exp_g = e.lat - 1;
    sb.push_back(e);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue_now(a, b);
  endtask

  // Wait for done (returns at the negedge where done is high), counting busy
  // cycles; optionally pulse a start with junk operands while busy.
  task automatic wait_done(input bit inject);
    int  n = 0;
    int  bc = 0;
    bit  inj = 0;
    forever begin
      @(negedge clk);
      if (inj) begin start = 1'b0; inj = 0; end
      if (done) break;
      if (busy) bc++;
      if (inject && busy && bc == 3) begin
        start = 1'b1; dividend = $urandom; divisor = $urandom; inj = 1;
      end
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL done_timeout: got no done in %0d cycles want done", n);
        return;
      end
    end
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("busy_cycles", 64'(bc), 64'(busy_exp_g));
  endtask

  initial begin
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {27'd0, busy, done, divisor_is_zero, quotient, remainder},
        64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    issue(32'd100, 32'd7);            wait_done(0);
    issue(32'h1234, 32'd0);           wait_done(0);
    issue(32'd5, 32'd9);              wait_done(0);
    issue(32'd0, 32'd0);              wait_done(0);
    issue(32'd1, 32'd1);              wait_done(0);
    issue(32'hFFFF_FFFF, 32'd1);      wait_done(1);
    issue(32'h8000_0000, 32'h8000_0000); wait_done(0);

    // Back-to-back: second start asserted in the first done cycle
    issue(32'd100, 32'd7);            wait_done(0);
    issue_now(32'd9, 32'd2);          wait_done(0);
    issue_now(32'd0, 32'd3);          wait_done(0);
    issue_now(32'd7, 32'd0);          wait_done(0);

    // Asynchronous reset mid-operation
    issue(32'hFFFF_FFFF, 32'd3);
    @(negedge clk); @(negedge clk);   // cycles 2 and 3
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {27'd0, busy, done, divisor_is_zero, quotient, remainder}, 64'd0);
    sb.delete();
    repeat (2) begin
      @(negedge clk);
      chk("done_in_reset", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    issue(32'd10, 32'd3);             wait_done(0);

    // Randomized sweep, mixing magnitudes and back-to-back starts
    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      a = a >> $urandom_range(0, 31);
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = a + 32'($urandom_range(1, 100));
        default: begin
          b = $urandom;
          b = b >> $urandom_range(0, 31);
          if (b == 0) b = 32'd1;
        end
      endcase
      if ($urandom_range(0, 1) == 1) issue_now(a, b);
      else issue(a, b);
      wait_done($urandom_range(0, 3) == 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
